rx_frame_assembler: RTL and testbench
=====================================

Name: rx_frame_assembler

Overview:
- Upstream stage of the hash-check receiver: collects a byte stream into one 2112-bit frame.
- Frame layout: message [2111:1600] followed by reference digest [1599:0].
- Delivers the frame, the header-carried bytenum and a one-cycle in_ready strobe to the receiver.
- Holds the frame stable until the next frame completes, so the comparison sees constant inputs while the hash core runs.

Parameters:
- FRAME_BYTES, 264: payload bytes per frame (264 × 8 = 2112).
- SYNC_MARK, 5'b10100: required value of header bits [7:3].
- TIMEOUT_CYC, 1024: idle cycles allowed between payload bytes (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx_byte  input  8  incoming byte.
- rx_valid  input  1  rx_byte is valid this cycle.
- rx_ready  output  1  block accepts rx_byte this cycle.
- rxin  output  2112  assembled frame; first payload byte lands at [2111:2104].
- bytenum  output  3  header bits [2:0] of the current frame.
- in_ready  output  1  one-cycle strobe: rxin/bytenum just updated.
- busy  output  1  high while in PAYLOAD.
- hdr_err  output  1  one-cycle strobe: a header byte was rejected.

Behaviour:
- Reset (async assert, sync release):
  - rxin=0, bytenum=0, in_ready=0, busy=0, hdr_err=0.
  - rx_ready=1, state=IDLE, byte counter=0.
- A byte transfers only on a clock edge where rx_valid & rx_ready are both high.
- States:
  - IDLE: rx_ready=1.
    - Accepted byte with [7:3]==SYNC_MARK: latch [2:0] into a shadow bytenum, clear counter, go to PAYLOAD.
    - Otherwise: drop the byte, pulse hdr_err next cycle, stay in IDLE.
  - PAYLOAD: rx_ready=1, busy=1.
    - Each accepted byte is shifted into a shadow shift register (left shift by 8, new byte in the LSBs); counter increments.
    - On the edge accepting byte number FRAME_BYTES-1 (counter==263): go to DONE.
  - DONE (exactly one cycle): rx_ready=0.
    - Shadow register copied to rxin and shadow bytenum to bytenum on entry.
    - in_ready=1 for this cycle only.
    - Next state is IDLE.
- Latency: in_ready is high in the cycle after the last payload byte is accepted.
- Stability: rxin and bytenum change only when in_ready=1; between frames they hold the last good frame.
- Counter: 9 bits. It never wraps, because it is cleared on header accept.
- rx_valid low in PAYLOAD: wait indefinitely, with no state change (unless the optional feature is enabled).
- Reset mid-frame:
  - Partial shadow data is discarded, and no in_ready or partial output is produced.
  - rxin returns to 0.
- A header byte arriving in the cycle immediately after DONE is accepted normally (back-to-back frames).
- Max throughput: one frame every 266 cycles (1 header + 264 payload + 1 DONE).

Optional Feature:
- Macro: RX_TIMEOUT_EN.
- Defined:
  - An idle counter runs in PAYLOAD, cleared on every accepted byte.
  - When it reaches TIMEOUT_CYC-1 with no byte accepted, the block aborts to IDLE: shadow data is discarded, rxin/bytenum are unchanged, and hdr_err pulses one cycle.
- Undefined: no counter is built, and PAYLOAD waits forever.

Decomposition:
- Shared package rx_pkg:
  - FRAME_BITS=2112, MSG_BITS=512, HASH_BITS=1600.
  - state enum {IDLE, PAYLOAD, DONE}.
  - SYNC_MARK default.
  - ASCII result constants for MSGCORRECT / M SGWRONG, so the receiver reuses them.
- One sub-module is natural: rx_shift_reg. It is the 2112-bit byte-wide shift register with a shift enable and clear, keeping the FSM file small.

Test Plan:
- Header 0xA5, then bytes 0x00..0xFF followed by 0x00..0x07 with continuous valid:
  - in_ready pulses once, 266 cycles after the header was accepted.
  - bytenum=3'd5.
  - rxin[2111:2104]=0x00, rxin[7:0]=0x07.
- Header 0x3C, then header 0xA1:
  - hdr_err pulses once and 0x3C is dropped.
  - The frame then completes normally with bytenum=1.
- Random rx_valid gaps (50% duty) over a full frame:
  - rxin matches the reference concatenation.
  - rx_ready=0 only in the DONE cycle.
  - rxin is unchanged until in_ready.
- Assert rst_n=0 after 100 payload bytes:
  - All outputs return to their reset values immediately (async).
  - A following complete frame is captured correctly.
- Two frames back-to-back:
  - in_ready pulses 266 cycles apart.
  - The second frame's rxin replaces the first only at the second pulse.
- With RX_TIMEOUT_EN and TIMEOUT_CYC=16, stop after 10 payload bytes:
  - hdr_err pulses at idle cycle 16.
  - State returns to IDLE and rxin keeps the previous frame.

Source files
------------

// File: rtl/rx_pkg.sv
// rtl/rx_pkg.sv - shared frame geometry, FSM encoding and result strings for the hash-check receiver
package rx_pkg;

    localparam int FRAME_BITS = 2112;
    localparam int MSG_BITS   = 512;
    localparam int HASH_BITS  = 1600;

    localparam logic [4:0] SYNC_MARK_DEF = 5'b10100;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        DONE    = 2'd2
    } rx_state_e;

    // Result strings emitted by the downstream comparator; MSGWRONG is zero-padded on the left
    localparam logic [79:0] RES_CORRECT = "MSGCORRECT";
    localparam logic [79:0] RES_WRONG   = "MSGWRONG";

endpackage

// File: rtl/rx_shift_reg.sv
// rtl/rx_shift_reg.sv - byte-wide shadow shift register holding the frame under assembly
module rx_shift_reg #(
    parameter int W = 2112
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         shift_en,
    input  logic [7:0]   din,
    output logic [W-1:0] q_next
);

    logic [W-1:0] q;

    // Exposing the post-shift value lets the final byte land in the frame on the same edge it arrives
    assign q_next = {q[W-9:0], din};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (shift_en) begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/rx_frame_assembler.sv
// rtl/rx_frame_assembler.sv - byte stream to 2112-bit frame assembler; RX_TIMEOUT_EN adds a payload idle abort
module rx_frame_assembler
    import rx_pkg::*;
#(
    parameter int         FRAME_BYTES = 264,
    parameter logic [4:0] SYNC_MARK   = SYNC_MARK_DEF,
    parameter int         TIMEOUT_CYC = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               rx_byte,
    input  logic                     rx_valid,
    output logic                     rx_ready,
    output logic [FRAME_BYTES*8-1:0] rxin,
    output logic [2:0]               bytenum,
    output logic                     in_ready,
    output logic                     busy,
    output logic                     hdr_err
);

    localparam int         W        = FRAME_BYTES * 8;
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_PAY   = PAYLOAD;
    localparam logic [1:0] ST_DONE  = DONE;
    localparam logic [8:0] CNT_LAST = 9'(FRAME_BYTES - 1);

    logic [1:0]   state;
    logic [8:0]   byte_cnt;
    logic [2:0]   bytenum_sh;
    logic [W-1:0] sh_next;
    logic         accept;
    logic         hdr_ok;
    logic         timeout;

    assign rx_ready = (state != ST_DONE);
    assign busy     = (state == ST_PAY);
    assign in_ready = (state == ST_DONE);
    assign accept   = rx_valid & rx_ready;
    assign hdr_ok   = (rx_byte[7:3] == SYNC_MARK);

    rx_shift_reg #(.W(W)) u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (accept & (state == ST_IDLE)),
        .shift_en (accept & busy),
        .din      (rx_byte),
        .q_next   (sh_next)
    );

`ifdef RX_TIMEOUT_EN
    localparam int IDLE_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [IDLE_W-1:0] idle_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (!busy || accept) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign timeout = busy && !accept && (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            byte_cnt   <= '0;
            bytenum_sh <= '0;
            rxin       <= '0;
            bytenum    <= '0;
            hdr_err    <= 1'b0;
        end else begin
            hdr_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (hdr_ok) begin
                            bytenum_sh <= rx_byte[2:0];
                            byte_cnt   <= '0;
                            state      <= ST_PAY;
                        end else begin
                            hdr_err <= 1'b1;
                        end
                    end
                end
                ST_PAY: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 1'b1;
                        // Publish on the last-byte edge so in_ready and the new frame appear together
                        if (byte_cnt == CNT_LAST) begin
                            rxin    <= sh_next;
                            bytenum <= bytenum_sh;
                            state   <= ST_DONE;
                        end
                    end else if (timeout) begin
                        hdr_err <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_frame_assembler.sv
// tb/tb_rx_frame_assembler.sv - self-checking bench for rx_frame_assembler (RX_TIMEOUT_EN selects the abort test)
`timescale 1ns/1ps
module tb_rx_frame_assembler;

    localparam int FB = 264;
    localparam int W  = FB * 8;
`ifdef RX_TIMEOUT_EN
    localparam int TO   = 16;
    localparam int DUTY = 80;
`else
    localparam int TO   = 1024;
    localparam int DUTY = 50;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   rx_byte = 8'h00;
    logic         rx_valid = 1'b0;
    logic         rx_ready;
    logic [W-1:0] rxin;
    logic [2:0]   bytenum;
    logic         in_ready;
    logic         busy;
    logic         hdr_err;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int hdr_cyc = 0;
    int done_cyc = 0;
    int done_a = 0;

    logic [7:0]   pay [FB];
    logic [W-1:0] exp_rxin = '0;
    logic [2:0]   exp_bn = '0;

    `define CHK(tag, obs, exp) \
        begin \
            n_chk++; \
            assert ((obs) === (exp)) else begin \
                n_fail++; \
                $error("FAIL %s: observed %0h expected %0h", tag, obs, exp); \
            end \
        end

    always #5 clk = ~clk;

    rx_frame_assembler #(
        .FRAME_BYTES (FB),
        .SYNC_MARK   (5'b10100),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .rxin     (rxin),
        .bytenum  (bytenum),
        .in_ready (in_ready),
        .busy     (busy),
        .hdr_err  (hdr_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_rxin(input string tag);
        int bad;
        int b;
        bad = -1;
        for (int j = FB - 1; j >= 0; j--)
            if (rxin[8*j +: 8] !== exp_rxin[8*j +: 8]) bad = j;
        b = (bad < 0) ? 0 : bad;
        n_chk++;
        assert (rxin === exp_rxin) else begin
            n_fail++;
            $error("FAIL %s: rxin byte at bit %0d observed %0h expected %0h", tag, 8*b, rxin[8*b +: 8], exp_rxin[8*b +: 8]);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_rxin(tag);
        `CHK({tag, "_bytenum"}, bytenum, 3'd0)
        `CHK({tag, "_in_ready"}, in_ready, 1'b0)
        `CHK({tag, "_busy"}, busy, 1'b0)
        `CHK({tag, "_hdr_err"}, hdr_err, 1'b0)
        `CHK({tag, "_rx_ready"}, rx_ready, 1'b1)
    endtask

    task automatic fill_rand();
        for (int j = 0; j < FB; j++) pay[j] = 8'($urandom);
    endtask

    // Drives one header plus FB payload bytes; returns in the DONE cycle with done_cyc set
    task automatic run_frame(input logic [7:0] hdr, input int duty, input int stall_at, input int stall_len, input string tag);
        bit acc;
        bit quiet_ok;
        int guard;
        quiet_ok = 1'b1;
        acc = 1'b0;
        guard = 0;
        rx_byte = hdr;
        rx_valid = 1'b1;
        while (!acc && guard < 4) begin
            acc = rx_ready;
            hdr_cyc = cyc;
            tick();
            guard++;
        end
        `CHK({tag, "_hdr_accept"}, acc, 1'b1)
        guard = 0;
        for (int i = 0; i < FB; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    rx_valid = 1'b0;
                    tick();
                    if (!(busy === 1'b1 && hdr_err === 1'b0 && in_ready === 1'b0 && rx_ready === 1'b1 && rxin === exp_rxin))
                        quiet_ok = 1'b0;
                end
            end
            acc = 1'b0;
            while (!acc && guard < 20000) begin
                rx_valid = ($urandom_range(99) < duty);
                rx_byte = rx_valid ? pay[i] : 8'($urandom);
                acc = rx_valid && rx_ready;
                tick();
                guard++;
                if (!acc || i < FB - 1) begin
                    if (!(busy === 1'b1 && hdr_err === 1'b0 && in_ready === 1'b0 && rx_ready === 1'b1 &&
                          rxin === exp_rxin && bytenum === exp_bn))
                        quiet_ok = 1'b0;
                end
            end
        end
        rx_valid = 1'b0;
        `CHK({tag, "_budget"}, guard < 20000, 1'b1)
        `CHK({tag, "_quiet_until_done"}, quiet_ok, 1'b1)
        for (int j = 0; j < FB; j++) exp_rxin[W-1-8*j -: 8] = pay[j];
        exp_bn = hdr[2:0];
        done_cyc = cyc;
        `CHK({tag, "_in_ready"}, in_ready, 1'b1)
        `CHK({tag, "_rx_ready_done"}, rx_ready, 1'b0)
        `CHK({tag, "_bytenum"}, bytenum, exp_bn)
        chk_rxin({tag, "_rxin"});
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Counting-pattern frame with continuous valid
        for (int j = 0; j < FB; j++) pay[j] = 8'(j);
        run_frame(8'hA5, 100, -1, 0, "count");
        `CHK("count_span", done_cyc - hdr_cyc + 1, 266)
        `CHK("count_bytenum5", bytenum, 3'd5)
        `CHK("count_first_byte", rxin[W-1 -: 8], 8'h00)
        `CHK("count_last_byte", rxin[7:0], 8'h07)
        tick();
        `CHK("count_pulse_once", in_ready, 1'b0)

        // Bad header dropped, then a good one
        rx_byte = 8'h3C;
        rx_valid = 1'b1;
        tick();
        `CHK("bad_hdr_err", hdr_err, 1'b1)
        `CHK("bad_hdr_idle", busy, 1'b0)
        fill_rand();
        run_frame(8'hA1, 100, -1, 0, "after_bad");
        `CHK("after_bad_bytenum1", bytenum, 3'd1)
        tick();

        // Random valid gaps
        fill_rand();
        run_frame(8'hA6, DUTY, -1, 0, "gaps");
        tick();

`ifndef RX_TIMEOUT_EN
        // Long stall mid-payload must simply wait
        fill_rand();
        run_frame(8'hA7, 100, 10, 40, "stall");
        tick();
`endif

        // Reset mid-frame
        rx_byte = 8'hA2;
        rx_valid = 1'b1;
        tick();
        for (int i = 0; i < 100; i++) begin
            rx_byte = 8'($urandom);
            tick();
        end
        rx_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        exp_rxin = '0;
        exp_bn = '0;
        chk_reset_outputs("async_rst");
        tick();
        rst_n = 1'b1;
        tick();
        fill_rand();
        run_frame(8'hA3, 100, -1, 0, "post_rst");
        tick();

        // Back-to-back frames
        fill_rand();
        run_frame(8'hA4, 100, -1, 0, "b2b_1");
        done_a = done_cyc;
        fill_rand();
        run_frame(8'hA0, 100, -1, 0, "b2b_2");
        `CHK("b2b_spacing", done_cyc - done_a, 266)
        tick();

`ifdef RX_TIMEOUT_EN
        // Payload stall aborts after TO idle cycles, keeping the last good frame
        begin
            bit to_ok;
            to_ok = 1'b1;
            rx_byte = 8'hA5;
            rx_valid = 1'b1;
            tick();
            for (int i = 0; i < 10; i++) begin
                rx_byte = 8'($urandom);
                tick();
            end
            rx_valid = 1'b0;
            for (int k = 1; k <= 20; k++) begin
                tick();
                if (!(hdr_err === (k == TO) && busy === (k < TO) && in_ready === 1'b0 && rxin === exp_rxin && bytenum === exp_bn))
                    to_ok = 1'b0;
            end
            `CHK("timeout_sequence", to_ok, 1'b1)
            `CHK("timeout_idle", busy, 1'b0)
            `CHK("timeout_rx_ready", rx_ready, 1'b1)
            chk_rxin("timeout_rxin_kept");
            fill_rand();
            run_frame(8'hA2, 100, -1, 0, "after_timeout");
            tick();
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
